registru_2: RTL and testbench

- 4-bit serial-in, parallel-out (SIPO) shift register.
- Samples one serial data bit per rising clock edge and presents the last WIDTH captured bits in parallel.
- Leaf block used wherever a serial bit stream must be widened into a parallel word, e.g. a deserializer front end or a pattern tap.
- No handshake and no framing: every clock edge shifts.

---
 rtl/registru_pkg.sv | 9 +
 rtl/registru_2.sv | 40 ++++
 tb/tb_registru_2.sv | 115 +++++++++++
 3 files changed

// File: rtl/registru_pkg.sv
// Shared constants and types for the registru serial-in parallel-out shifter.
package registru_pkg;

  localparam int REG_WIDTH_DEFAULT  = 4;
  localparam int SHIFT_LEFT_DEFAULT = 1;

  typedef logic [REG_WIDTH_DEFAULT-1:0] reg_word_t;

endpackage : registru_pkg

// File: rtl/registru_2.sv
// Serial-in, parallel-out shift register. Every rising clock edge shifts one
// bit of a into the entry stage; O is taken straight from the stage flops, so
// there is no combinational path from a to O.
module registru_2
  import registru_pkg::*;
#(
  parameter int WIDTH      = REG_WIDTH_DEFAULT,
  parameter int SHIFT_LEFT = SHIFT_LEFT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  output logic [WIDTH-1:0] O
);

  // A single-stage register has no chain to shift through.
  if (WIDTH < 2) begin : g_width_check
    $error("registru_2: WIDTH must be 2 or more, got %0d", WIDTH);
  end

  // Stage chain: reset clears every stage at once; otherwise the entry stage
  // (O[0] when shifting left, O[WIDTH-1] when shifting right) takes a and
  // each remaining stage takes its upstream neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O <= '0;
    end else if (SHIFT_LEFT != 0) begin
      O[0] <= a;
      for (int i = 1; i < WIDTH; i++) begin
        O[i] <= O[i-1];
      end
    end else begin
      O[WIDTH-1] <= a;
      for (int i = 0; i < WIDTH-1; i++) begin
        O[i] <= O[i+1];
      end
    end
  end

endmodule : registru_2

// File: tb/tb_registru_2.sv
// Directed bench for registru_2: a 4-bit left shifter, a 4-bit right shifter
// and an 8-bit left shifter share clock and reset, each with its own serial input.
`timescale 1ns/1ps
module tb_registru_2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       a_l   = 1'b0;
  logic       a_r   = 1'b0;
  logic       a_w   = 1'b0;
  logic [3:0] o_l;
  logic [3:0] o_r;
  logic [7:0] o_w;

  int tests  = 0;
  int failed = 0;

  registru_2 #(.WIDTH(4), .SHIFT_LEFT(1)) dut_l (.clk(clk), .rst_n(rst_n), .a(a_l), .O(o_l));
  registru_2 #(.WIDTH(4), .SHIFT_LEFT(0)) dut_r (.clk(clk), .rst_n(rst_n), .a(a_r), .O(o_r));
  registru_2 #(.WIDTH(8), .SHIFT_LEFT(1)) dut_w (.clk(clk), .rst_n(rst_n), .a(a_w), .O(o_w));

  // 500 ns period, first rising edge at 250 ns
  always #250 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // advance one rising edge and land 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] alt_a   [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [3:0] alt_exp [10] = '{4'h1, 4'h3, 4'h6, 4'hC, 4'h9, 4'h3, 4'h6, 4'hC, 4'h9, 4'h3};
  logic [7:0] fill_exp[10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
  logic [3:0] walk_exp[5]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
  logic [3:0] dir_exp [5]  = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h0};

  initial begin
    // Reset held across several edges with a=1
    a_l = 1'b1; a_r = 1'b1; a_w = 1'b1;
    #5 rst_n = 1'b0;
    #5;
    check("reset_l_async", {4'h0, o_l}, 8'h00);
    check("reset_r_async", {4'h0, o_r}, 8'h00);
    check("reset_w_async", o_w, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step();
      check("reset_hold_l", {4'h0, o_l}, 8'h00);
      check("reset_hold_r", {4'h0, o_r}, 8'h00);
      check("reset_hold_w", o_w, 8'h00);
    end
    a_r = 1'b0;
    #100 rst_n = 1'b1;
    #100;
    check("release_no_edge_l", {4'h0, o_l}, 8'h00);
    check("release_no_edge_w", o_w, 8'h00);

    // Alternating pairs on the left shifter, constant fill on the wide one
    for (int k = 0; k < 10; k++) begin
      a_l = alt_a[k][0];
      step();
      check($sformatf("alt_l_%0d", k), {4'h0, o_l}, {4'h0, alt_exp[k]});
      check($sformatf("fill_w_%0d", k), o_w, fill_exp[k]);
      check($sformatf("idle_r_%0d", k), {4'h0, o_r}, 8'h00);
    end

    // Flush the left shifter, then walk a single one through it
    a_l = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("flush_l", {4'h0, o_l}, 8'h00);
    a_l = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      a_l = 1'b0;
      check($sformatf("walk_l_%0d", k), {4'h0, o_l}, {4'h0, walk_exp[k]});
    end

    // Fill to 1111, then reset between edges
    a_l = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("fill_l", {4'h0, o_l}, 8'h0F);
    check("wide_still_full", o_w, 8'hFF);
    #100 rst_n = 1'b0;
    #10;
    check("mid_reset_l", {4'h0, o_l}, 8'h00);
    check("mid_reset_w", o_w, 8'h00);
    #50 rst_n = 1'b1;
    #10;
    check("mid_release_l", {4'h0, o_l}, 8'h00);

    // First edge after release; right shifter also gets a=1 then 0
    a_r = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      a_r = 1'b0;
      a_l = 1'b0;
      if (k == 0) begin
        check("restart_l", {4'h0, o_l}, 8'h01);
        check("restart_w", o_w, 8'h01);
      end
      check($sformatf("dir_r_%0d", k), {4'h0, o_r}, {4'h0, dir_exp[k]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_registru_2
